// File: rtl/keypad_scan_pkg.sv
// Shared definitions for the 4x4 matrix keypad scanner.
//   - Debounce FSM state encoding
//   - Scan result classification (none / exactly one / multiple keys)
//   - eval_scan(): turns a 16-bit "key is down" vector into a scan result.
//     Bit index = row_idx*4 + col_idx, which is also the reported key code.
package keypad_scan_pkg;

  localparam int CODE_W = 4;
  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int KEYS   = ROWS * COLS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_DB,
    ST_PRESSED,
    ST_REL_DB
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_ONE,
    RES_MULTI
  } scan_kind_t;

  typedef struct packed {
    scan_kind_t          kind;
    logic [CODE_W-1:0]   code;
  } scan_res_t;

  // Count the active positions; when exactly one is active, its index is the
  // key code. With zero or several active the code is meaningless.
  function automatic scan_res_t eval_scan(input logic [KEYS-1:0] hits);
    scan_res_t res;
    logic [4:0] n;
    res.kind = RES_NONE;
    res.code = '0;
    n        = '0;
    for (int i = 0; i < KEYS; i++) begin
      if (hits[i]) begin
        n        = n + 5'd1;
        res.code = CODE_W'(i);
      end
    end
    if (n == 5'd1) begin
      res.kind = RES_ONE;
    end else if (n > 5'd1) begin
      res.kind = RES_MULTI;
    end
    return res;
  endfunction

endpackage

// File: rtl/keypad_scan_debounce.sv
// Press/release debouncer for the keypad scanner.
// Evaluated once per completed full scan of the matrix.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   scan_done    one-cycle strobe: a full 4-row scan has just completed
//   result       classification of that scan (none / one / multi)
//   code         key code when result is RES_ONE
//   key          last accepted key code (kept after release)
//   key_valid    one-cycle pulse when a press is accepted
//   key_held     high from accepted press until accepted release
import keypad_scan_pkg::*;

module keypad_scan_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_done,
  input  scan_kind_t        result,
  input  logic [CODE_W-1:0] code,
  output logic [CODE_W-1:0] key,
  output logic              key_valid,
  output logic              key_held
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t            state_reg, state_next;
  logic [CODE_W-1:0] cand_reg, cand_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [CODE_W-1:0] key_reg, key_next;
  logic              key_valid_reg, key_valid_next;
  logic              key_held_reg, key_held_next;

  logic             is_one;
  logic [CNT_W-1:0] cnt_inc;

  assign is_one  = (result == RES_ONE);
  // The counter only ever increments while below DEBOUNCE (reaching it
  // always leaves the state), so it saturates naturally.
  assign cnt_inc = cnt_reg + CNT_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cand_reg      <= '0;
      cnt_reg       <= '0;
      key_reg       <= '0;
      key_valid_reg <= 1'b0;
      key_held_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cand_reg      <= cand_next;
      cnt_reg       <= cnt_next;
      key_reg       <= key_next;
      key_valid_reg <= key_valid_next;
      key_held_reg  <= key_held_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cand_next      = cand_reg;
    cnt_next       = cnt_reg;
    key_next       = key_reg;
    key_valid_next = 1'b0;
    key_held_next  = key_held_reg;

    if (scan_done) begin
      case (state_reg)
        ST_IDLE: begin
          if (is_one) begin
            if (DEBOUNCE == 1) begin
              state_next     = ST_PRESSED;
              key_next       = code;
              key_valid_next = 1'b1;
              key_held_next  = 1'b1;
              cnt_next       = '0;
            end else begin
              state_next = ST_PRESS_DB;
              cand_next  = code;
              cnt_next   = CNT_ONE;
            end
          end
        end

        ST_PRESS_DB: begin
          if (is_one && (code == cand_reg)) begin
            if (cnt_inc == CNT_MAX) begin
              state_next     = ST_PRESSED;
              key_next       = cand_reg;
              key_valid_next = 1'b1;
              key_held_next  = 1'b1;
              cnt_next       = '0;
            end else begin
              cnt_next = cnt_inc;
            end
          end else if (is_one) begin
            // A different single key restarts the candidate.
            cand_next = code;
            cnt_next  = CNT_ONE;
          end else begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end
        end

        ST_PRESSED: begin
          // Anything but the held key alone counts as a release scan; a
          // second key is never reported until the release is accepted.
          if (!(is_one && (code == key_reg))) begin
            if (DEBOUNCE == 1) begin
              state_next    = ST_IDLE;
              key_held_next = 1'b0;
              cnt_next      = '0;
            end else begin
              state_next = ST_REL_DB;
              cnt_next   = CNT_ONE;
            end
          end
        end

        ST_REL_DB: begin
          if (is_one && (code == key_reg)) begin
            // Bounce back to held without a new pulse.
            state_next = ST_PRESSED;
            cnt_next   = '0;
          end else if (cnt_inc == CNT_MAX) begin
            state_next    = ST_IDLE;
            key_held_next = 1'b0;
            cnt_next      = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end

        default: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  assign key       = key_reg;
  assign key_valid = key_valid_reg;
  assign key_held  = key_held_reg;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner.
// Drives one row low at a time, synchronizes the column lines, assembles a
// full 16-key snapshot every four row dwells and hands it to the debouncer.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   row[3:0]     row drive, active-low, exactly one bit low
//   col[3:0]     column sense, active-low, asynchronous to clk
//   key[3:0]     accepted key code = row_idx*4 + col_idx
//   key_valid    one-cycle pulse per accepted press
//   key_held     high while an accepted press has not been released
import keypad_scan_pkg::*;

module keypad_scan #(
  parameter int CLK_DIV  = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ROWS-1:0]   row,
  input  logic [COLS-1:0]   col,
  output logic [CODE_W-1:0] key,
  output logic              key_valid,
  output logic              key_held
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [COLS-1:0]  col_meta_reg, col_sync_reg;
  logic [DIV_W-1:0] div_cnt_reg;
  logic [1:0]       row_idx_reg;
  logic [COLS-1:0]  scan_buf_reg [0:ROWS-2];
  logic [ROWS-1:0]  row_sel;
  logic [KEYS-1:0]  hits;
  logic             tick;
  logic             scan_done;
  scan_res_t        scan_res;

  // Two-flop synchronizer; idle (pulled-up) level out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta_reg <= '1;
      col_sync_reg <= '1;
    end else begin
      col_meta_reg <= col;
      col_sync_reg <= col_meta_reg;
    end
  end

  assign tick = (div_cnt_reg == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg <= '0;
      row_idx_reg <= '0;
    end else begin
      div_cnt_reg <= tick ? '0 : div_cnt_reg + 1'b1;
      if (tick) begin
        row_idx_reg <= row_idx_reg + 2'd1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      assign row_sel[gi] = (row_idx_reg == 2'(gi));
      assign row[gi]     = ~row_sel[gi];
    end
  endgenerate

  // Only rows 0..2 need storing: row 3 is consumed directly on the
  // scan-complete tick so the result is ready on that same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS - 1; r++) begin
        scan_buf_reg[r] <= '1;
      end
    end else if (tick) begin
      for (int r = 0; r < ROWS - 1; r++) begin
        if (row_sel[r]) begin
          scan_buf_reg[r] <= col_sync_reg;
        end
      end
    end
  end

  generate
    for (gi = 0; gi < ROWS - 1; gi++) begin : g_hits
      assign hits[gi*COLS +: COLS] = ~scan_buf_reg[gi];
    end
  endgenerate
  assign hits[(ROWS-1)*COLS +: COLS] = ~col_sync_reg;

  assign scan_done = tick && row_sel[ROWS-1];
  assign scan_res  = eval_scan(hits);

  keypad_scan_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .scan_done (scan_done),
    .result    (scan_res.kind),
    .code      (scan_res.code),
    .key       (key),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan with CLK_DIV=4, DEBOUNCE=3 (16 clocks per full scan).
// A behavioural keypad ties the pressed-key mask to the row/col lines.
module tb_keypad_scan;

  localparam int CLK_DIV  = 4;
  localparam int DEBOUNCE = 3;
  localparam int SCAN     = 4 * CLK_DIV;

  logic       clk;
  logic       rst_n;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed;
  int          pulse_cnt;
  int          passed;
  int          total;

  keypad_scan #(
    .CLK_DIV  (CLK_DIV),
    .DEBOUNCE (DEBOUNCE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .key       (key),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its column to a low row.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row[r] && pressed[r*4+c]) col[c] = 1'b0;
      end
    end
  end

  // Each high sample counts, so a two-cycle strobe would show up as two.
  always @(negedge clk) begin
    if (key_valid) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic run_scans(input int n);
    repeat (n * SCAN) @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] mask;
    int          scans;
    int          pulses;
    logic [3:0]  key;
    logic        held;
  } vec_t;

  vec_t vecs [26];

  initial begin
    int p0;
    logic [3:0] exp_row;

    // mask, scans, pulses in window, key, key_held at end of window
    vecs[0]  = '{16'h0200, 2, 0, 4'd9, 1'b0};
    vecs[1]  = '{16'h0200, 1, 1, 4'd9, 1'b1};
    vecs[2]  = '{16'h0200, 4, 0, 4'd9, 1'b1};
    vecs[3]  = '{16'h0000, 2, 0, 4'd9, 1'b1};
    vecs[4]  = '{16'h0000, 1, 0, 4'd9, 1'b0};
    vecs[5]  = '{16'h0200, 1, 0, 4'd9, 1'b0};   // bounce on/off
    vecs[6]  = '{16'h0000, 1, 0, 4'd9, 1'b0};
    vecs[7]  = '{16'h0200, 1, 0, 4'd9, 1'b0};
    vecs[8]  = '{16'h0000, 1, 0, 4'd9, 1'b0};
    vecs[9]  = '{16'h0200, 3, 1, 4'd9, 1'b1};   // then stable
    vecs[10] = '{16'h0000, 3, 0, 4'd9, 1'b0};
    vecs[11] = '{16'h0021, 4, 0, 4'd9, 1'b0};   // keys 0 and 5 together
    vecs[12] = '{16'h0001, 3, 1, 4'd0, 1'b1};   // release 5
    vecs[13] = '{16'h0000, 3, 0, 4'd0, 1'b0};
    vecs[14] = '{16'h0200, 3, 1, 4'd9, 1'b1};   // hold 9
    vecs[15] = '{16'h0208, 1, 0, 4'd9, 1'b1};   // add 3
    vecs[16] = '{16'h0008, 1, 0, 4'd9, 1'b1};   // switch to 3 only
    vecs[17] = '{16'h0000, 1, 0, 4'd9, 1'b0};   // third release scan
    vecs[18] = '{16'h0000, 2, 0, 4'd9, 1'b0};
    vecs[19] = '{16'h0008, 3, 1, 4'd3, 1'b1};   // press 3
    vecs[20] = '{16'h0000, 3, 0, 4'd3, 1'b0};
    vecs[21] = '{16'h0008, 3, 1, 4'd3, 1'b1};
    vecs[22] = '{16'h0000, 2, 0, 4'd3, 1'b1};   // release bounce
    vecs[23] = '{16'h0008, 1, 0, 4'd3, 1'b1};
    vecs[24] = '{16'h0000, 2, 0, 4'd3, 1'b1};
    vecs[25] = '{16'h0000, 1, 0, 4'd3, 1'b0};

    passed    = 0;
    total     = 0;
    pulse_cnt = 0;
    pressed   = '0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_row", 32'(row), 32'h0000000E);
    check("rst_key", 32'(key), 32'h0);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_held", 32'(key_held), 32'h0);

    // Idle scanning: row advances every CLK_DIV clocks, nothing reported.
    rst_n = 1'b1;
    for (int k = 0; k < 2 * SCAN; k++) begin
      exp_row = ~(4'b0001 << ((k / CLK_DIV) % 4));
      check($sformatf("idle_row_c%0d", k), 32'(row), 32'(exp_row));
      check($sformatf("idle_valid_c%0d", k), 32'(key_valid | key_held), 32'h0);
      @(negedge clk);
    end
    $display("idle scan: %0d rows checked", 2 * SCAN);

    // Exact acceptance point: pulse right after the 3rd scan-complete edge.
    pressed = 16'h0200;
    repeat (DEBOUNCE * SCAN - 1) @(negedge clk);
    check("lat_before_valid", 32'(key_valid), 32'h0);
    check("lat_before_held", 32'(key_held), 32'h0);
    @(negedge clk);
    check("lat_valid", 32'(key_valid), 32'h1);
    check("lat_key", 32'(key), 32'd9);
    check("lat_held", 32'(key_held), 32'h1);
    @(negedge clk);
    check("lat_valid_width", 32'(key_valid), 32'h0);
    check("lat_held_after", 32'(key_held), 32'h1);
    repeat (SCAN - 1) @(negedge clk);
    pressed = '0;
    run_scans(DEBOUNCE);
    check("lat_release_held", 32'(key_held), 32'h0);
    $display("latency: key 9 at cycle %0d of press", DEBOUNCE * SCAN);

    for (int i = 0; i < 26; i++) begin
      pressed = vecs[i].mask;
      p0 = pulse_cnt;
      run_scans(vecs[i].scans);
      check($sformatf("vec%0d_pulses", i), 32'(pulse_cnt - p0), 32'(vecs[i].pulses));
      check($sformatf("vec%0d_key", i), 32'(key), 32'(vecs[i].key));
      check($sformatf("vec%0d_held", i), 32'(key_held), 32'(vecs[i].held));
      $display("vec %0d: mask=%04h scans=%0d pulses=%0d key=%0d held=%0b",
               i, vecs[i].mask, vecs[i].scans, pulse_cnt - p0, key, key_held);
    end

    // Reset in the middle of a press debounce discards it.
    pressed = 16'h0200;
    p0 = pulse_cnt;
    run_scans(2);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("clr_row", 32'(row), 32'h0000000E);
    check("clr_key", 32'(key), 32'h0);
    check("clr_valid", 32'(key_valid), 32'h0);
    check("clr_held", 32'(key_held), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_scans(DEBOUNCE - 1);
    check("clr_no_pulse", 32'(pulse_cnt - p0), 32'h0);
    check("clr_no_held", 32'(key_held), 32'h0);
    run_scans(1);
    check("clr_resume_pulse", 32'(pulse_cnt - p0), 32'h1);
    check("clr_resume_key", 32'(key), 32'd9);
    check("clr_resume_held", 32'(key_held), 32'h1);
    $display("clr mid-debounce: pulses=%0d key=%0d", pulse_cnt - p0, key);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
